// File: rtl/obi_xbar_varlat_arb.sv
// obi_xbar_varlat_arb
//   N-to-1 OBI arbiter that funnels several OBI masters onto one slave port.
//   Responses are routed back in order through an outstanding-ID FIFO.
//
//   Parameters
//     NMASTER         number of masters (2..16)
//     MAX_OUTSTANDING depth of the outstanding-ID FIFO (power of two, 1..16)
//     ARB_MODE        0 = round-robin, 1 = fixed priority (lowest index wins)
//
//   Ports
//     clk_i          clock
//     rst_i          synchronous active-high reset
//     master_req_i   per-master request (req, addr, we, be, wdata)
//     master_resp_o  per-master response (gnt, rvalid, rdata)
//     slave_req_o    merged request to the slave
//     slave_resp_i   slave response (gnt, rvalid, rdata)
//     outstanding_o  number of transactions in flight
//     err_o          sticky: rvalid seen with nothing in flight
//
//   Optional feature macro: OBI_XBAR_PERF_CNT_EN
//     Adds cnt_clr_i and grant_cnt_o[NMASTER], one saturating 32-bit grant
//     counter per master. Arbitration is unaffected by the macro.

package obi_xbar_varlat_arb_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_xbar_varlat_arb
  import obi_xbar_varlat_arb_pkg::*;
#(
  parameter int unsigned NMASTER         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ARB_MODE        = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  obi_req_t                             master_req_i  [NMASTER],
  output obi_resp_t                            master_resp_o [NMASTER],
  output obi_req_t                             slave_req_o,
  input  obi_resp_t                            slave_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
`ifdef OBI_XBAR_PERF_CNT_EN
  ,
  input  logic                                 cnt_clr_i,
  output logic [31:0]                          grant_cnt_o [NMASTER]
`endif
);

  localparam int unsigned IDW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NMASTER - 1);
  localparam logic [PW-1:0]  LAST_SLOT = PW'(MAX_OUTSTANDING - 1);

  logic [IDW-1:0] rr_ptr;
  logic           lock_valid;
  logic [IDW-1:0] lock_idx;
  logic [IDW-1:0] id_mem [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           err_q;

  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  int unsigned    cand;
  logic [IDW-1:0] win_idx;
  logic           win_valid;
  logic           fifo_full;
  logic           fifo_empty;
  logic           handshake;
  logic           pop;
  logic [IDW-1:0] head_id;
  logic [NMASTER-1:0] gnt_vec;

  assign fifo_full  = (count == MAX_CNT);
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];

  // Candidate scan starting at the RR pointer (mode 0) or at index 0 (mode 1).
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NMASTER; i++) begin
      if (ARB_MODE == 0) begin
        cand = 32'(rr_ptr) + i;
        if (cand >= NMASTER) cand = cand - NMASTER;
      end else begin
        cand = i;
      end
      if (!arb_found && master_req_i[IDW'(cand)].req) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(cand);
      end
    end
  end

  // A held lock pins the selection; if the locked master withdraws, the
  // request to the slave drops and the lock clears on the next edge.
  assign win_idx   = lock_valid ? lock_idx : arb_idx;
  assign win_valid = lock_valid ? master_req_i[lock_idx].req : arb_found;

  always_comb begin
    slave_req_o     = master_req_i[win_idx];
    slave_req_o.req = win_valid && !fifo_full && !rst_i;
  end

  assign handshake = slave_req_o.req && slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid && !fifo_empty && !rst_i;

  always_comb begin
    gnt_vec = '0;
    for (int unsigned i = 0; i < NMASTER; i++) begin
      master_resp_o[i].gnt    = handshake && (win_idx == IDW'(i));
      master_resp_o[i].rvalid = pop && (head_id == IDW'(i));
      master_resp_o[i].rdata  = slave_resp_i.rdata;
      gnt_vec[i]              = master_resp_o[i].gnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
    end else if (handshake) begin
      lock_valid <= 1'b0;
      rr_ptr     <= (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
    end else if (slave_req_o.req) begin
      lock_valid <= 1'b1;
      lock_idx   <= win_idx;
    end else if (lock_valid && !master_req_i[lock_idx].req) begin
      lock_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (handshake) id_mem[wr_ptr] <= win_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (handshake) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      if (pop)       rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      case ({handshake, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (slave_resp_i.rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign outstanding_o = count;
  assign err_o         = err_q;

`ifdef OBI_XBAR_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NMASTER; i++) begin
      if (rst_i || cnt_clr_i) begin
        grant_cnt_o[i] <= '0;
      end else if (gnt_vec[i] && (grant_cnt_o[i] != '1)) begin
        grant_cnt_o[i] <= grant_cnt_o[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_obi_xbar_varlat_arb.sv
module tb_obi_xbar_varlat_arb;
  import obi_xbar_varlat_arb_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  obi_req_t  mreq [4];
  obi_resp_t sresp;

  obi_resp_t rr_mresp [4];
  obi_resp_t fp_mresp [4];
  obi_req_t  rr_sreq, fp_sreq;
  logic [2:0] rr_out, fp_out;
  logic      rr_err, fp_err;
`ifdef OBI_XBAR_PERF_CNT_EN
  logic        cnt_clr;
  logic [31:0] rr_cnt [4];
  logic [31:0] fp_cnt [4];
`endif

  int nvec = 0;
  int nerr = 0;
  int order [4] = '{1, 3, 0, 2};

  always #5 clk = ~clk;

  obi_xbar_varlat_arb #(.NMASTER(4), .MAX_OUTSTANDING(4), .ARB_MODE(0)) u_rr (
    .clk_i(clk), .rst_i(rst), .master_req_i(mreq), .master_resp_o(rr_mresp),
    .slave_req_o(rr_sreq), .slave_resp_i(sresp), .outstanding_o(rr_out), .err_o(rr_err)
`ifdef OBI_XBAR_PERF_CNT_EN
    , .cnt_clr_i(cnt_clr), .grant_cnt_o(rr_cnt)
`endif
  );

  obi_xbar_varlat_arb #(.NMASTER(4), .MAX_OUTSTANDING(4), .ARB_MODE(1)) u_fp (
    .clk_i(clk), .rst_i(rst), .master_req_i(mreq), .master_resp_o(fp_mresp),
    .slave_req_o(fp_sreq), .slave_resp_i(sresp), .outstanding_o(fp_out), .err_o(fp_err)
`ifdef OBI_XBAR_PERF_CNT_EN
    , .cnt_clr_i(cnt_clr), .grant_cnt_o(fp_cnt)
`endif
  );

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      mreq[i].req   = m[i];
      mreq[i].addr  = addr_of(i);
      mreq[i].we    = 1'b0;
      mreq[i].be    = 4'hF;
      mreq[i].wdata = 32'(i);
    end
  endtask

  task automatic set_slave(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    sresp.gnt    = gnt;
    sresp.rvalid = rvalid;
    sresp.rdata  = rdata;
  endtask

  function automatic int rr_rv_cnt();
    int n = 0;
    for (int i = 0; i < 4; i++) if (rr_mresp[i].rvalid) n++;
    return n;
  endfunction

  function automatic int rr_gnt_cnt();
    int n = 0;
    for (int i = 0; i < 4; i++) if (rr_mresp[i].gnt) n++;
    return n;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    set_req(4'b0000);
    set_slave(1'b0, 1'b0, '0);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
`ifdef OBI_XBAR_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    do_reset();
    #1;
    chk("reset_outstanding", 32'(rr_out), 0);
    chk("reset_err", 32'(rr_err), 0);
    chk("reset_slave_req", 32'(rr_sreq.req), 0);
    chk("reset_gnt_count", 32'(rr_gnt_cnt()), 0);

    // Round-robin fairness, gnt every cycle, rvalid one cycle later.
    for (int k = 0; k < 6; k++) begin
      cyc();
      set_req(4'b1111);
      set_slave(1'b1, k > 0, 32'h0000_00D0 + 32'(k));
      #1;
      chk($sformatf("rr_addr_%0d", k), rr_sreq.addr, addr_of(k % 4));
      chk($sformatf("rr_gnt_%0d", k), 32'(rr_mresp[k % 4].gnt), 1);
      chk($sformatf("rr_gnt_onehot_%0d", k), 32'(rr_gnt_cnt()), 1);
      if (k > 0) begin
        chk($sformatf("rr_rvalid_%0d", k), 32'(rr_mresp[(k - 1) % 4].rvalid), 1);
        chk($sformatf("rr_rdata_%0d", k), rr_mresp[(k - 1) % 4].rdata, 32'h0000_00D0 + 32'(k));
        chk($sformatf("rr_outst_%0d", k), 32'(rr_out), 1);
      end
    end
    cyc();
    set_req(4'b0000);
    set_slave(1'b0, 1'b1, 32'h0000_00FF);
    #1;
    chk("rr_last_rvalid", 32'(rr_mresp[1].rvalid), 1);
    cyc();
    set_slave(1'b0, 1'b0, '0);
    #1;
    chk("rr_drained", 32'(rr_out), 0);

    // Fixed priority with lock: master 2 held while master 0 joins.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc();
      set_req(k == 0 ? 4'b0100 : 4'b0101);
      set_slave(k == 3, 1'b0, '0);
      #1;
      chk($sformatf("fp_lock_addr_%0d", k), fp_sreq.addr, addr_of(2));
      chk($sformatf("fp_m2_gnt_%0d", k), 32'(fp_mresp[2].gnt), (k == 3) ? 1 : 0);
      chk($sformatf("fp_m0_gnt_%0d", k), 32'(fp_mresp[0].gnt), 0);
    end
    cyc();
    set_req(4'b0101);
    set_slave(1'b1, 1'b0, '0);
    #1;
    chk("fp_next_addr", fp_sreq.addr, addr_of(0));
    chk("fp_next_m0_gnt", 32'(fp_mresp[0].gnt), 1);
    chk("fp_next_m2_gnt", 32'(fp_mresp[2].gnt), 0);

    // Fill the FIFO from masters 1,3,0,2 and drain in order.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc();
      set_req(4'(1 << order[k]));
      set_slave(1'b1, 1'b0, '0);
      #1;
      chk($sformatf("fill_gnt_%0d", k), 32'(rr_mresp[order[k]].gnt), 1);
    end
    cyc();
    set_req(4'b0010);
    set_slave(1'b1, 1'b0, '0);
    #1;
    chk("full_outstanding", 32'(rr_out), 4);
    chk("full_req_blocked", 32'(rr_sreq.req), 0);
    chk("full_no_gnt", 32'(rr_mresp[1].gnt), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      set_req(k == 0 ? 4'b0010 : 4'b0000);
      set_slave(1'b1, 1'b1, 32'hCAFE_0000 + 32'(k));
      #1;
      chk($sformatf("drain_rvalid_%0d", k), 32'(rr_mresp[order[k]].rvalid), 1);
      chk($sformatf("drain_rdata_%0d", k), rr_mresp[order[k]].rdata, 32'hCAFE_0000 + 32'(k));
      chk($sformatf("drain_onehot_%0d", k), 32'(rr_rv_cnt()), 1);
      if (k == 0) chk("full_pop_still_blocked", 32'(rr_sreq.req), 0);
    end
    cyc();
    set_req(4'b0000);
    set_slave(1'b0, 1'b0, '0);
    #1;
    chk("drain_empty", 32'(rr_out), 0);

    // Push and pop in the same cycle with two in flight.
    set_req(4'b0001);
    set_slave(1'b1, 1'b0, '0);
    cyc();
    set_req(4'b0010);
    cyc();
    set_req(4'b0100);
    set_slave(1'b1, 1'b1, 32'h0000_BEEF);
    #1;
    chk("pp_pre_outstanding", 32'(rr_out), 2);
    chk("pp_rvalid_oldest", 32'(rr_mresp[0].rvalid), 1);
    chk("pp_rvalid_m1", 32'(rr_mresp[1].rvalid), 0);
    chk("pp_gnt_m2", 32'(rr_mresp[2].gnt), 1);
    cyc();
    set_req(4'b0000);
    set_slave(1'b0, 1'b1, 32'h0000_0001);
    #1;
    chk("pp_post_outstanding", 32'(rr_out), 2);
    chk("pp_next_m1", 32'(rr_mresp[1].rvalid), 1);
    cyc();
    set_slave(1'b0, 1'b1, 32'h0000_0002);
    #1;
    chk("pp_next_m2", 32'(rr_mresp[2].rvalid), 1);
    cyc();
    set_slave(1'b0, 1'b0, '0);
    #1;
    chk("pp_empty", 32'(rr_out), 0);

    // Spurious response after reset.
    do_reset();
    cyc();
    set_slave(1'b0, 1'b1, 32'h0000_0BAD);
    #1;
    chk("spur_no_rvalid", 32'(rr_rv_cnt()), 0);
    chk("spur_err_not_yet", 32'(rr_err), 0);
    cyc();
    set_slave(1'b0, 1'b0, '0);
    #1;
    chk("spur_err_set", 32'(rr_err), 1);
    chk("spur_outst_zero", 32'(rr_out), 0);
    cyc();
    cyc();
    #1;
    chk("spur_err_sticky", 32'(rr_err), 1);
    do_reset();
    #1;
    chk("spur_err_cleared", 32'(rr_err), 0);

    // Reset with three transactions in flight.
    set_req(4'b0001);
    set_slave(1'b1, 1'b0, '0);
    cyc();
    cyc();
    cyc();
    #1;
    chk("mid_outstanding", 32'(rr_out), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_low", 32'(rr_sreq.req), 0);
    chk("mid_rst_no_gnt", 32'(rr_mresp[0].gnt), 0);
    cyc();
    rst = 1'b0;
    set_slave(1'b0, 1'b0, '0);
    #1;
    chk("mid_rst_outstanding", 32'(rr_out), 0);
`ifdef OBI_XBAR_PERF_CNT_EN
    for (int i = 0; i < 4; i++) chk($sformatf("cnt_rst_%0d", i), rr_cnt[i], 0);
`endif
    for (int k = 0; k < 5; k++) begin
      cyc();
      set_req(4'b0001);
      set_slave(1'b1, k > 0, '0);
      #1;
      chk($sformatf("post_rst_gnt_%0d", k), 32'(rr_mresp[0].gnt), 1);
    end
    cyc();
    set_req(4'b0000);
    set_slave(1'b0, 1'b1, '0);
    #1;
`ifdef OBI_XBAR_PERF_CNT_EN
    chk("cnt_m0_five", rr_cnt[0], 5);
    chk("cnt_m1_zero", rr_cnt[1], 0);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    #1;
    chk("cnt_cleared", rr_cnt[0], 0);
`endif
    cyc();
    set_slave(1'b0, 1'b0, '0);
    #1;
    chk("final_empty", 32'(rr_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
